// File: rtl/uart_reg_ctrl_pkg.sv
// Shared definitions for the UART register-access command sequencer.
// Holds the controller state encoding, the command-byte layout constants,
// the data value returned when a register read times out, and a helper
// function that turns clock/bit-rate settings into an inter-byte timeout
// expressed in clock cycles.
package uart_reg_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_DATA,
        WRITE,
        READ_REQ,
        READ_WAIT,
        TX,
        TX_HOLD
    } state_t;

    localparam int CMD_WR_BIT = 7;

    localparam logic [7:0] RD_TIMEOUT_DATA = 8'hFF;

    // Whole clock cycles per bit, times the number of bit periods allowed
    // between bytes; the per-bit figure is truncated before the multiply.
    function automatic int to_cycles(input int clk_hz, input int bit_rate, input int bits);
        return (clk_hz / bit_rate) * bits;
    endfunction

endpackage

// File: rtl/uart_reg_ctrl_if.sv
// Bundle of every non-clock signal between the command sequencer and its
// neighbours (UART receiver/transmitter, register bank, status outputs).
// Modports:
//   master - the sequencer: consumes rx bytes, tx busy and read data,
//            drives tx strobe/data, register bus and status pulses.
//   slave  - the surrounding logic: the mirror image of master.
interface uart_reg_ctrl_if #(
    parameter int ADDR_W = 7
);

    logic              uart_rx_valid;
    logic [7:0]        uart_rx_data;
    logic              uart_rx_break;
    logic              uart_tx_busy;
    logic              uart_tx_en;
    logic [7:0]        uart_tx_data;
    logic [ADDR_W-1:0] reg_addr;
    logic [7:0]        reg_wdata;
    logic              reg_wr_en;
    logic              reg_rd_en;
    logic [7:0]        reg_rdata;
    logic              reg_rd_valid;
    logic              busy;
    logic              err_timeout;
    logic              err_drop;

    modport master (
        input  uart_rx_valid, uart_rx_data, uart_rx_break, uart_tx_busy,
        input  reg_rdata, reg_rd_valid,
        output uart_tx_en, uart_tx_data, reg_addr, reg_wdata, reg_wr_en, reg_rd_en,
        output busy, err_timeout, err_drop
    );

    modport slave (
        output uart_rx_valid, uart_rx_data, uart_rx_break, uart_tx_busy,
        output reg_rdata, reg_rd_valid,
        input  uart_tx_en, uart_tx_data, reg_addr, reg_wdata, reg_wr_en, reg_rd_en,
        input  busy, err_timeout, err_drop
    );

endinterface

// File: rtl/uart_reg_ctrl_timer.sv
// Loadable saturating down-counter used for the controller's timeouts.
// Ports:
//   clk, reset - system clock, synchronous active-high reset (reloads)
//   clear_i    - reload the counter with START
//   en_i       - count down by one per cycle, stopping at zero
//   expire_o   - high while enabled and the count has reached zero
// With START = N-1 and en_i held from the first cycle of a wait, expire_o
// rises in the N-th cycle of that wait.
module uart_reg_ctrl_timer #(
    parameter int W     = 8,
    parameter int START = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic clear_i,
    input  logic en_i,
    output logic expire_o
);

    localparam logic [W-1:0] START_V = W'(START);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Clear wins over counting; once at zero the count stays there until
    // the owner leaves the waiting state and clears it again.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = START_V;
        end else if (en_i && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    // Plain state register; reset puts the counter back at its start value.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= START_V;
        end else begin
            count_q <= count_d;
        end
    end

    assign expire_o = en_i && (count_q == '0);

endmodule

// File: rtl/uart_reg_ctrl.sv
// Command sequencer between the UART and an 8-bit register bank.
// A received byte with bit 7 set starts a write (address, then value byte);
// with bit 7 clear it starts a read whose result is sent back over the UART.
// Handles inter-byte and read-response timeouts, line-break abort and
// reporting of bytes that arrive while a command is in progress.
// Ports:
//   clk   - system clock
//   reset - synchronous active-high reset
//   bus   - uart_reg_ctrl_if master modport (UART, register bank, status)
module uart_reg_ctrl
    import uart_reg_ctrl_pkg::*;
#(
    parameter int CLK_HZ       = 50000000,
    parameter int BIT_RATE     = 9600,
    parameter int ADDR_W       = 7,
    parameter int TIMEOUT_BITS = 20,
    parameter int RD_WAIT_MAX  = 15
) (
    input  logic            clk,
    input  logic            reset,
    uart_reg_ctrl_if.master bus
);

    localparam int TO_CYC = to_cycles(CLK_HZ, BIT_RATE, TIMEOUT_BITS);
    localparam int TO_W   = $clog2(TO_CYC + 1);
    localparam int RD_W   = $clog2(RD_WAIT_MAX + 1);

    state_t            state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [7:0]        wdata_q;
    logic [7:0]        tx_data_q;
    logic              wr_en_q;
    logic              rd_en_q;
    logic              tx_en_q;
    logic              err_to_q;
    logic              to_expire;
    logic              rd_expire;

    // Inter-byte timer: held loaded outside WAIT_DATA, so every entry
    // (including after a break) starts a fresh wait.
    uart_reg_ctrl_timer #(
        .W     (TO_W),
        .START (TO_CYC - 1)
    ) u_byte_timer (
        .clk      (clk),
        .reset    (reset),
        .clear_i  (state_q != WAIT_DATA),
        .en_i     (state_q == WAIT_DATA),
        .expire_o (to_expire)
    );

    // Read-response timer, same scheme for READ_WAIT.
    uart_reg_ctrl_timer #(
        .W     (RD_W),
        .START (RD_WAIT_MAX - 1)
    ) u_read_timer (
        .clk      (clk),
        .reset    (reset),
        .clear_i  (state_q != READ_WAIT),
        .en_i     (state_q == READ_WAIT),
        .expire_o (rd_expire)
    );

    // Main sequencer. Strobes and error pulses are registered and default
    // low every cycle, so each one lasts exactly one cycle and lines up with
    // the state it belongs to (WRITE, READ_REQ, TX_HOLD). A line break sends
    // the machine home and suppresses whatever this cycle would have issued.
    // An arriving byte beats an expiring inter-byte timer, and register data
    // beats an expiring read timer.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            tx_data_q <= '0;
            wr_en_q   <= 1'b0;
            rd_en_q   <= 1'b0;
            tx_en_q   <= 1'b0;
            err_to_q  <= 1'b0;
        end else begin
            wr_en_q  <= 1'b0;
            rd_en_q  <= 1'b0;
            tx_en_q  <= 1'b0;
            err_to_q <= 1'b0;
            if (bus.uart_rx_break) begin
                state_q <= IDLE;
            end else begin
                unique case (state_q)
                    IDLE: begin
                        if (bus.uart_rx_valid) begin
                            addr_q <= bus.uart_rx_data[ADDR_W-1:0];
                            if (bus.uart_rx_data[CMD_WR_BIT]) begin
                                state_q <= WAIT_DATA;
                            end else begin
                                state_q <= READ_REQ;
                                rd_en_q <= 1'b1;
                            end
                        end
                    end
                    WAIT_DATA: begin
                        if (bus.uart_rx_valid) begin
                            wdata_q <= bus.uart_rx_data;
                            wr_en_q <= 1'b1;
                            state_q <= WRITE;
                        end else if (to_expire) begin
                            err_to_q <= 1'b1;
                            state_q  <= IDLE;
                        end
                    end
                    WRITE: begin
                        state_q <= IDLE;
                    end
                    READ_REQ: begin
                        state_q <= READ_WAIT;
                    end
                    READ_WAIT: begin
                        if (bus.reg_rd_valid) begin
                            tx_data_q <= bus.reg_rdata;
                            state_q   <= TX;
                        end else if (rd_expire) begin
                            tx_data_q <= RD_TIMEOUT_DATA;
                            err_to_q  <= 1'b1;
                            state_q   <= TX;
                        end
                    end
                    TX: begin
                        if (!bus.uart_tx_busy) begin
                            tx_en_q <= 1'b1;
                            state_q <= TX_HOLD;
                        end
                    end
                    TX_HOLD: begin
                        state_q <= IDLE;
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    // A byte landing mid-command is flagged in the very cycle it arrives,
    // so this pulse is decoded directly from the current state and inputs.
    assign bus.err_drop = !reset && bus.uart_rx_valid && !bus.uart_rx_break &&
                          (state_q inside {WRITE, READ_REQ, READ_WAIT, TX, TX_HOLD});

    assign bus.busy         = (state_q != IDLE);
    assign bus.reg_addr     = addr_q;
    assign bus.reg_wdata    = wdata_q;
    assign bus.reg_wr_en    = wr_en_q;
    assign bus.reg_rd_en    = rd_en_q;
    assign bus.uart_tx_en   = tx_en_q;
    assign bus.uart_tx_data = tx_data_q;
    assign bus.err_timeout  = err_to_q;

endmodule

// File: tb/tb_uart_reg_ctrl.sv
// Self-checking bench for uart_reg_ctrl.
// Each directed step pushes the events it should cause (kind, value and the
// clock cycle they must appear in) onto a scoreboard queue; a monitor pops
// and compares whenever the DUT raises a strobe or error pulse. A small
// register-bank responder answers reads after a programmable delay.
// The clock rate is scaled down so the inter-byte timeout is 400 cycles.
module tb_uart_reg_ctrl;

    localparam int CLK_HZ       = 192000;
    localparam int BIT_RATE     = 9600;
    localparam int ADDR_W       = 7;
    localparam int TIMEOUT_BITS = 20;
    localparam int RD_WAIT_MAX  = 15;
    localparam int TO_CYC       = (CLK_HZ / BIT_RATE) * TIMEOUT_BITS;

    localparam int K_NONE = 0;
    localparam int K_WR   = 1;
    localparam int K_RD   = 2;
    localparam int K_TX   = 3;
    localparam int K_TO   = 4;
    localparam int K_DROP = 5;

    typedef struct {
        int          kind;
        logic [15:0] val;
        int          cyc;
    } exp_t;

    logic clk;
    logic reset;
    int   cyc;
    int   checks;
    int   errors;
    bit   armed;
    int   rsp_delay;
    logic [7:0] rsp_data;
    exp_t sb[$];

    uart_reg_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

    uart_reg_ctrl #(
        .CLK_HZ       (CLK_HZ),
        .BIT_RATE     (BIT_RATE),
        .ADDR_W       (ADDR_W),
        .TIMEOUT_BITS (TIMEOUT_BITS),
        .RD_WAIT_MAX  (RD_WAIT_MAX)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Free-running 10-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle index used to timestamp expected and observed events.
    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic pushExp(input int kind, input logic [15:0] val, input int c);
        exp_t e;
        e.kind = kind;
        e.val  = val;
        e.cyc  = c;
        sb.push_back(e);
    endtask

    task automatic observe(input int kind, input logic [15:0] val);
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
        end else begin
            e.kind = K_NONE;
            e.val  = 16'h0;
            e.cyc  = -1;
        end
        checkOutput($sformatf("event_kind@%0d", cyc), kind, e.kind);
        checkOutput($sformatf("event_val_k%0d", kind), {16'h0, val}, {16'h0, e.val});
        checkOutput($sformatf("event_cycle_k%0d", kind), cyc, e.cyc);
    endtask

    // Present one received byte; returns the cycle in which the strobe is high.
    task automatic applyStimulus(input logic [7:0] b, output int c);
        @(posedge clk);
        #1;
        bus.uart_rx_valid = 1'b1;
        bus.uart_rx_data  = b;
        c = cyc;
    endtask

    task automatic releaseRx();
        @(posedge clk);
        #1;
        bus.uart_rx_valid = 1'b0;
    endtask

    // Monitor: every strobe or pulse seen mid-cycle must match the head of
    // the scoreboard, and at most one register/UART strobe may be active.
    initial begin
        forever begin
            @(negedge clk);
            if (armed) begin
                checkOutput("strobe_onehot",
                            32'(bus.reg_wr_en) + 32'(bus.reg_rd_en) + 32'(bus.uart_tx_en) <= 1, 1);
                if (bus.reg_wr_en === 1'b1)   observe(K_WR, {1'b0, bus.reg_addr, bus.reg_wdata});
                if (bus.reg_rd_en === 1'b1)   observe(K_RD, {9'h0, bus.reg_addr});
                if (bus.uart_tx_en === 1'b1)  observe(K_TX, {8'h0, bus.uart_tx_data});
                if (bus.err_timeout === 1'b1) observe(K_TO, 16'h0);
                if (bus.err_drop === 1'b1)    observe(K_DROP, 16'h0);
            end
        end
    end

    // Register-bank model: answers each read strobe rsp_delay cycles later
    // with rsp_data; a negative delay means it never answers.
    initial begin
        bus.reg_rd_valid = 1'b0;
        bus.reg_rdata    = 8'h00;
        forever begin
            @(negedge clk);
            if (bus.reg_rd_en === 1'b1 && rsp_delay >= 0) begin
                repeat (rsp_delay) @(posedge clk);
                #1;
                bus.reg_rd_valid = 1'b1;
                bus.reg_rdata    = rsp_data;
                @(posedge clk);
                #1;
                bus.reg_rd_valid = 1'b0;
                bus.reg_rdata    = 8'h00;
            end
        end
    end

    // Directed sequence of command scenarios.
    initial begin : main
        int c;
        int d;
        checks    = 0;
        errors    = 0;
        armed     = 1'b0;
        rsp_delay = -1;
        rsp_data  = 8'h00;
        reset             = 1'b1;
        bus.uart_rx_valid = 1'b1;
        bus.uart_rx_data  = 8'h81;
        bus.uart_rx_break = 1'b0;
        bus.uart_tx_busy  = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_outputs",
                    {3'b0, bus.uart_tx_en, bus.uart_tx_data, bus.reg_addr, bus.reg_wdata,
                     bus.reg_wr_en, bus.reg_rd_en, bus.busy, bus.err_timeout, bus.err_drop}, 32'h0);
        reset             = 1'b0;
        bus.uart_rx_valid = 1'b0;
        bus.uart_rx_data  = 8'h00;
        @(posedge clk);
        #1;
        armed = 1'b1;
        checkOutput("idle_after_reset", bus.busy, 0);

        $display("[TB] write 0x01 <= 0xA5");
        applyStimulus(8'h81, c);
        releaseRx();
        repeat (98) @(posedge clk);
        applyStimulus(8'hA5, c);
        pushExp(K_WR, 16'h01A5, c + 1);
        releaseRx();
        repeat (5) @(posedge clk);
        #1;
        checkOutput("write_idle_after", bus.busy, 0);

        $display("[TB] read 0x03, bank answers 0x5C after 3 cycles");
        rsp_delay = 3;
        rsp_data  = 8'h5C;
        applyStimulus(8'h03, c);
        pushExp(K_RD, 16'h0003, c + 1);
        pushExp(K_TX, 16'h005C, c + 6);
        releaseRx();
        repeat (12) @(posedge clk);
        #1;
        checkOutput("read_idle_after", bus.busy, 0);

        $display("[TB] read 0x06 with transmitter busy for 500 cycles");
        bus.uart_tx_busy = 1'b1;
        rsp_delay = 2;
        rsp_data  = 8'h3C;
        applyStimulus(8'h06, c);
        pushExp(K_RD, 16'h0006, c + 1);
        releaseRx();
        repeat (500) @(posedge clk);
        #1;
        checkOutput("busy_held_in_tx", bus.busy, 1);
        pushExp(K_TX, 16'h003C, cyc + 1);
        bus.uart_tx_busy = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        checkOutput("txbusy_idle_after", bus.busy, 0);

        $display("[TB] inter-byte timeout after 0x82");
        applyStimulus(8'h82, c);
        pushExp(K_TO, 16'h0, c + TO_CYC + 1);
        releaseRx();
        repeat (TO_CYC + 5) @(posedge clk);
        #1;
        checkOutput("timeout_idle_after", bus.busy, 0);
        applyStimulus(8'h83, c);
        releaseRx();
        repeat (3) @(posedge clk);
        applyStimulus(8'h11, c);
        pushExp(K_WR, 16'h0311, c + 1);
        releaseRx();
        repeat (5) @(posedge clk);

        $display("[TB] read 0x04 with no bank response");
        rsp_delay = -1;
        applyStimulus(8'h04, c);
        pushExp(K_RD, 16'h0004, c + 1);
        pushExp(K_TO, 16'h0, c + 17);
        pushExp(K_TX, 16'h00FF, c + 18);
        releaseRx();
        repeat (25) @(posedge clk);
        #1;
        checkOutput("rdtimeout_idle_after", bus.busy, 0);

        $display("[TB] break aborts pending write, then read 0x10");
        rsp_delay = 1;
        rsp_data  = 8'h77;
        applyStimulus(8'h85, c);
        releaseRx();
        repeat (3) @(posedge clk);
        #1;
        checkOutput("wait_data_busy", bus.busy, 1);
        bus.uart_rx_break = 1'b1;
        bus.uart_rx_valid = 1'b1;
        bus.uart_rx_data  = 8'h99;
        @(posedge clk);
        #1;
        bus.uart_rx_break = 1'b0;
        bus.uart_rx_valid = 1'b0;
        checkOutput("break_to_idle", bus.busy, 0);
        applyStimulus(8'h10, c);
        pushExp(K_RD, 16'h0010, c + 1);
        pushExp(K_TX, 16'h0077, c + 4);
        releaseRx();
        repeat (TO_CYC + 10) @(posedge clk);

        $display("[TB] byte during READ_WAIT is dropped");
        rsp_delay = 5;
        rsp_data  = 8'hC3;
        applyStimulus(8'h20, d);
        pushExp(K_RD, 16'h0020, d + 1);
        releaseRx();
        applyStimulus(8'h8F, c);
        pushExp(K_DROP, 16'h0, c);
        pushExp(K_TX, 16'h00C3, d + 8);
        releaseRx();
        repeat (15) @(posedge clk);
        #1;
        checkOutput("drop_idle_after", bus.busy, 0);

        repeat (20) @(posedge clk);
        #1;
        checkOutput("scoreboard_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_reg_ctrl.md
Name: uart_reg_ctrl

Overview:
- Command sequencer between the UART receiver/transmitter and an 8-bit register bank in impl_top.
- Parses the received byte stream into register writes (address byte, then value byte) and register reads (address byte only).
- For each read, fetches the register value and returns it through the UART transmitter.
- Owns inter-byte timeout, abort on line break, and error reporting.

Parameters:
- CLK_HZ, 50000000, system clock frequency in Hz.
- BIT_RATE, 9600, UART bit rate; sets the timeout base.
- ADDR_W, 7, register address width; command byte bits [ADDR_W-1:0].
- TIMEOUT_BITS, 20, inter-byte timeout in bit periods. Timeout cycles TO_CYC = (CLK_HZ/BIT_RATE)*TIMEOUT_BITS, integer division.
- RD_WAIT_MAX, 15, maximum cycles from reg_rd_en to reg_rd_valid.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- uart_rx_valid  in  1  one-cycle strobe: a received byte is on uart_rx_data.
- uart_rx_data  in  8  received byte.
- uart_rx_break  in  1  line break detected (level).
- uart_tx_busy  in  1  transmitter busy.
- uart_tx_en  out  1  one-cycle strobe: start transmission of uart_tx_data.
- uart_tx_data  out  8  byte to transmit.
- reg_addr  out  ADDR_W  register address.
- reg_wdata  out  8  write data.
- reg_wr_en  out  1  one-cycle write strobe.
- reg_rd_en  out  1  one-cycle read strobe.
- reg_rdata  in  8  read data; sampled when reg_rd_valid=1.
- reg_rd_valid  in  1  read data valid.
- busy  out  1  high whenever the state is not IDLE.
- err_timeout  out  1  one-cycle pulse: inter-byte timeout or read-response timeout.
- err_drop  out  1  one-cycle pulse: received byte discarded.

Behaviour:
- Reset (synchronous, active-high):
  - All outputs are 0; reg_addr=0, reg_wdata=0, uart_tx_data=0.
  - State=IDLE; counters cleared.
  - Reset overrides every other event in the same cycle.
- Command byte: bit7=1 is a write, bit7=0 is a read. Bits [ADDR_W-1:0] are the address; bits between ADDR_W and 7 are ignored.
- IDLE:
  - On uart_rx_valid, latch reg_addr.
  - Write command: go to WAIT_DATA and clear the timeout counter.
  - Read command: go to READ_REQ.
- WAIT_DATA:
  - On uart_rx_valid, latch reg_wdata and go to WRITE.
  - The counter increments every cycle. At count TO_CYC-1 with no byte: pulse err_timeout, go to IDLE, issue no write.
  - If uart_rx_valid and the timeout occur in the same cycle, the byte wins.
- WRITE: reg_wr_en=1 for exactly one cycle, then IDLE. Write latency from the value byte strobe to reg_wr_en is 1 cycle.
- READ_REQ: reg_rd_en=1 for one cycle, then READ_WAIT. Latency from the command byte strobe to reg_rd_en is 1 cycle.
- READ_WAIT:
  - On reg_rd_valid, latch uart_tx_data=reg_rdata and go to TX.
  - After RD_WAIT_MAX cycles without reg_rd_valid: latch uart_tx_data=8'hFF, pulse err_timeout, go to TX.
- TX:
  - While uart_tx_busy=1, hold.
  - In the first cycle with uart_tx_busy=0, assert uart_tx_en for one cycle, then go to TX_HOLD.
- TX_HOLD: one cycle, so the transmitter's busy can rise; then IDLE.
- Dropped bytes: uart_rx_valid in READ_REQ, READ_WAIT, TX, TX_HOLD or WRITE discards the byte and pulses err_drop in the same cycle. It never starts a new command.
- uart_rx_break=1 in any state:
  - Next state is IDLE; counters cleared.
  - reg_wr_en, reg_rd_en and uart_tx_en are not asserted in that cycle.
  - uart_rx_valid in the same cycle is ignored.
- Strobes:
  - No strobe (reg_wr_en, reg_rd_en, uart_tx_en) is ever asserted for more than one cycle.
  - At most one of them is asserted in any cycle.
- Counters: TO counter width is clog2(TO_CYC+1); RD counter width is clog2(RD_WAIT_MAX+1). Neither wraps; both saturate until the state exits.

Decomposition:
- Package uart_reg_ctrl_pkg:
  - State encoding enum: IDLE, WAIT_DATA, WRITE, READ_REQ, READ_WAIT, TX, TX_HOLD.
  - Constant CMD_WR_BIT=7.
  - Constant RD_TIMEOUT_DATA=8'hFF.
  - A function computing TO_CYC from CLK_HZ, BIT_RATE and TIMEOUT_BITS.
- Sub-module: uart_reg_ctrl_timer, a loadable saturating down-counter with clear and expire outputs. It is instanced twice: inter-byte timeout and read-response timeout.

Test Plan:
- Write: rx bytes 8'h81 then 8'hA5, 100 cycles apart -> one-cycle reg_wr_en with reg_addr=7'h01 and reg_wdata=8'hA5, exactly 1 cycle after the second strobe; no tx; busy low afterward.
- Read: rx 8'h03; register bank returns 8'h5C with reg_rd_valid 3 cycles after reg_rd_en -> reg_rd_en 1 cycle after the strobe, reg_addr=7'h03, then uart_tx_en with uart_tx_data=8'h5C.
- Read with uart_tx_busy held high for 500 cycles -> uart_tx_en is held back and asserts in the first cycle busy=0.
- Inter-byte timeout: rx 8'h82, then silence -> err_timeout pulses after TO_CYC cycles (104160 at defaults), no reg_wr_en. A following 8'h83 is treated as a command.
- Read timeout: rx 8'h04 with reg_rd_valid never asserted -> err_timeout after 15 cycles, then uart_tx_en with 8'hFF.
- Abort and drop:
  - rx 8'h85, then uart_rx_break pulse, then rx 8'h10 -> no write; 8'h10 is handled as a read of 7'h10.
  - A byte arriving during READ_WAIT -> err_drop pulse; the state machine is unaffected.
